// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared constants, state encoding and MEM/WB field bundle
package mem_stage_pkg;

    localparam int DATA_W = 16;
    localparam int REG_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    typedef struct packed {
        logic              hlt;
        logic              from_mem;
        logic              write_reg;
        logic [REG_W-1:0]  dst_reg;
        logic [DATA_W-1:0] mem_data;
        logic [DATA_W-1:0] dst_data;
    } memwb_t;

endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - upstream, data-memory and MEM/WB signals of the MEM stage
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic              d_hlt;
    logic              d_from_mem;
    logic              d_mem_wr;
    logic              d_WriteReg;
    logic [REG_W-1:0]  d_DstReg;
    logic [DATA_W-1:0] d_Addr;
    logic [DATA_W-1:0] d_StoreData;
    logic [DATA_W-1:0] d_DstData;

    logic              mem_req;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic              out_valid;
    logic              out_ready;
    logic              q_hlt;
    logic              q_from_mem;
    logic              q_WriteReg;
    logic [REG_W-1:0]  q_DstReg;
    logic [DATA_W-1:0] q_MemData;
    logic [DATA_W-1:0] q_DstData;
    logic              halted;

    modport master (
        output in_valid, d_hlt, d_from_mem, d_mem_wr, d_WriteReg, d_DstReg,
               d_Addr, d_StoreData, d_DstData, mem_rdata, mem_ready, out_ready,
        input  in_ready, mem_req, mem_wr, mem_addr, mem_wdata, out_valid,
               q_hlt, q_from_mem, q_WriteReg, q_DstReg, q_MemData, q_DstData, halted
    );

    modport slave (
        input  in_valid, d_hlt, d_from_mem, d_mem_wr, d_WriteReg, d_DstReg,
               d_Addr, d_StoreData, d_DstData, mem_rdata, mem_ready, out_ready,
        output in_ready, mem_req, mem_wr, mem_addr, mem_wdata, out_valid,
               q_hlt, q_from_mem, q_WriteReg, q_DstReg, q_MemData, q_DstData, halted
    );

endinterface

// File: rtl/mem_stage_slot.sv
// rtl/mem_stage_slot.sv - MEM/WB output holding register with free/valid tracking
module mem_stage_slot
    import mem_stage_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load_i,
    input  memwb_t data_i,
    input  logic   out_ready_i,
    output logic   free_o,
    output logic   out_valid_o,
    output memwb_t q_o
);

    logic   valid_q, valid_d;
    memwb_t data_q;

    // A full slot still counts as free when downstream takes it this cycle.
    assign free_o  = !valid_q || out_ready_i;
    assign valid_d = load_i ? 1'b1 : (out_ready_i ? 1'b0 : valid_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            if (load_i)
                data_q <= data_i;
        end
    end

    always_comb begin
        q_o           = data_q;
        q_o.hlt       = data_q.hlt && valid_q;
        q_o.write_reg = data_q.write_reg && valid_q;
    end

    assign out_valid_o = valid_q;

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: load/store over a req/ready memory port
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    mem_stage_if.slave  bus
);

    state_t            state_q, state_d;
    memwb_t            lat_q, lat_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic              halted_q, halted_d;

    logic              free;
    logic              slot_load;
    memwb_t            slot_d;
    memwb_t            slot_q;
    logic              slot_valid;
    logic              in_ready;
    logic              mem_req;
    logic              in_is_mem;

    assign in_is_mem = bus.d_from_mem || bus.d_mem_wr;

    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_d      = wr_q;
        halted_d  = halted_q;
        slot_load = 1'b0;
        slot_d    = '0;
        in_ready  = 1'b0;
        mem_req   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = free && !halted_q;
                if (bus.in_valid && in_ready) begin
                    if (in_is_mem) begin
                        // A store wins when both flags are set; it never writes a register.
                        lat_d.hlt       = bus.d_hlt;
                        lat_d.from_mem  = bus.d_from_mem && !bus.d_mem_wr;
                        lat_d.write_reg = bus.d_WriteReg && !bus.d_mem_wr;
                        lat_d.dst_reg   = bus.d_DstReg;
                        lat_d.mem_data  = '0;
                        lat_d.dst_data  = bus.d_DstData;
                        addr_d          = bus.d_Addr;
                        wdata_d         = bus.d_StoreData;
                        wr_d            = bus.d_mem_wr;
                        state_d         = ST_REQ;
                    end else begin
                        slot_load          = 1'b1;
                        slot_d.hlt         = bus.d_hlt;
                        slot_d.write_reg   = bus.d_WriteReg;
                        slot_d.dst_reg     = bus.d_DstReg;
                        slot_d.dst_data    = bus.d_DstData;
                        if (bus.d_hlt) begin
                            halted_d = 1'b1;
                            state_d  = ST_HALT;
                        end
                    end
                end
            end
            ST_REQ: begin
                // Request is withheld while the slot cannot take the result.
                mem_req = free;
                if (free && bus.mem_ready) begin
                    slot_load = 1'b1;
                    slot_d    = lat_q;
                    if (!wr_q)
                        slot_d.mem_data = bus.mem_rdata;
                    state_d   = ST_IDLE;
                end
            end
            ST_HALT: begin
                in_ready = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            lat_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lat_q    <= lat_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wr_q     <= wr_d;
            halted_q <= halted_d;
        end
    end

    mem_stage_slot u_slot (
        .clk         (clk),
        .rst         (rst),
        .load_i      (slot_load),
        .data_i      (slot_d),
        .out_ready_i (bus.out_ready),
        .free_o      (free),
        .out_valid_o (slot_valid),
        .q_o         (slot_q)
    );

    assign bus.in_ready   = in_ready;
    assign bus.mem_req    = mem_req;
    assign bus.mem_wr     = wr_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.out_valid  = slot_valid;
    assign bus.q_hlt      = slot_q.hlt;
    assign bus.q_from_mem = slot_q.from_mem;
    assign bus.q_WriteReg = slot_q.write_reg;
    assign bus.q_DstReg   = slot_q.dst_reg;
    assign bus.q_MemData  = slot_q.mem_data;
    assign bus.q_DstData  = slot_q.dst_data;
    assign bus.halted     = halted_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mem_stage_if bus ();

    mem_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [15:0] data;
        logic [3:0]  dst;
        logic        exp_ir;
        logic        exp_ov;
        logic [15:0] exp_data;
        logic [3:0]  exp_dst;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_in();
        bus.in_valid    = 1'b0;
        bus.d_hlt       = 1'b0;
        bus.d_from_mem  = 1'b0;
        bus.d_mem_wr    = 1'b0;
        bus.d_WriteReg  = 1'b0;
        bus.d_DstReg    = '0;
        bus.d_Addr      = '0;
        bus.d_StoreData = '0;
        bus.d_DstData   = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        clear_in();
        bus.mem_rdata = '0;
        bus.mem_ready = 1'b0;
        bus.out_ready = 1'b1;

        tbl[0] = '{1'b1, 16'd1, 4'd1, 1'b1, 1'b0, 16'd0, 4'd0};
        tbl[1] = '{1'b1, 16'd2, 4'd2, 1'b1, 1'b1, 16'd1, 4'd1};
        tbl[2] = '{1'b1, 16'd3, 4'd3, 1'b1, 1'b1, 16'd2, 4'd2};
        tbl[3] = '{1'b1, 16'd4, 4'd4, 1'b1, 1'b1, 16'd3, 4'd3};
        tbl[4] = '{1'b0, 16'd0, 4'd0, 1'b1, 1'b1, 16'd4, 4'd4};
        tbl[5] = '{1'b0, 16'd0, 4'd0, 1'b1, 1'b0, 16'd0, 4'd0};

        // reset state
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_halted", bus.halted, 0);
        chk("rst_q_hlt", bus.q_hlt, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_q_DstData", bus.q_DstData, 0);
        rst = 1'b0;

        // reset mid-request
        @(negedge clk);
        bus.in_valid = 1'b1; bus.d_from_mem = 1'b1; bus.d_Addr = 16'h0010;
        @(negedge clk);
        clear_in();
        #1;
        chk("mreq_req_before", bus.mem_req, 1);
        chk("mreq_addr_before", bus.mem_addr, 16'h0010);
        rst = 1'b1;
        #1;
        chk("mreq_req_async", bus.mem_req, 0);
        chk("mreq_ov_async", bus.out_valid, 0);
        chk("mreq_halted_async", bus.halted, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mreq_in_ready_after", bus.in_ready, 1);

        // streaming ALU ops
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.in_valid   = tbl[i].iv;
            bus.d_WriteReg = 1'b1;
            bus.d_DstData  = tbl[i].data;
            bus.d_DstReg   = tbl[i].dst;
            #1;
            chk($sformatf("stream%0d_in_ready", i), bus.in_ready, tbl[i].exp_ir);
            chk($sformatf("stream%0d_out_valid", i), bus.out_valid, tbl[i].exp_ov);
            if (tbl[i].exp_ov) begin
                chk($sformatf("stream%0d_q_DstData", i), bus.q_DstData, tbl[i].exp_data);
                chk($sformatf("stream%0d_q_DstReg", i), bus.q_DstReg, tbl[i].exp_dst);
                chk($sformatf("stream%0d_q_WriteReg", i), bus.q_WriteReg, 1);
                chk($sformatf("stream%0d_q_MemData", i), bus.q_MemData, 0);
            end else begin
                chk($sformatf("stream%0d_q_WriteReg_bubble", i), bus.q_WriteReg, 0);
            end
        end
        clear_in();

        // load with three cycles of memory latency
        @(negedge clk);
        bus.in_valid = 1'b1; bus.d_from_mem = 1'b1; bus.d_Addr = 16'h0020;
        bus.d_DstReg = 4'd5; bus.d_WriteReg = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            clear_in();
            if (c == 3) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = 16'hBEEF;
            end
            #1;
            chk($sformatf("load_req_c%0d", c), bus.mem_req, 1);
            chk($sformatf("load_addr_c%0d", c), bus.mem_addr, 16'h0020);
            chk($sformatf("load_in_ready_c%0d", c), bus.in_ready, 0);
            chk($sformatf("load_ov_c%0d", c), bus.out_valid, 0);
        end
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        chk("load_req_drop", bus.mem_req, 0);
        chk("load_out_valid", bus.out_valid, 1);
        chk("load_q_MemData", bus.q_MemData, 16'hBEEF);
        chk("load_q_from_mem", bus.q_from_mem, 1);
        chk("load_q_DstReg", bus.q_DstReg, 5);
        chk("load_q_WriteReg", bus.q_WriteReg, 1);

        // store completing on the first request cycle
        @(negedge clk);
        bus.in_valid = 1'b1; bus.d_mem_wr = 1'b1; bus.d_Addr = 16'h0004;
        bus.d_StoreData = 16'h1234; bus.d_WriteReg = 1'b1; bus.d_DstReg = 4'd9;
        @(negedge clk);
        clear_in();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'hFFFF;
        #1;
        chk("store_req", bus.mem_req, 1);
        chk("store_mem_wr", bus.mem_wr, 1);
        chk("store_wdata", bus.mem_wdata, 16'h1234);
        chk("store_addr", bus.mem_addr, 16'h0004);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        chk("store_out_valid", bus.out_valid, 1);
        chk("store_q_WriteReg", bus.q_WriteReg, 0);
        chk("store_q_MemData", bus.q_MemData, 0);
        chk("store_q_from_mem", bus.q_from_mem, 0);

        // downstream stall with memory always ready
        @(negedge clk);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'h5A5A;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.d_WriteReg = 1'b1; bus.d_DstReg = 4'd3; bus.d_DstData = 16'h00AA;
        @(negedge clk);
        clear_in();
        bus.in_valid = 1'b1; bus.d_from_mem = 1'b1; bus.d_Addr = 16'h0030;
        bus.d_DstReg = 4'd7; bus.d_WriteReg = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk($sformatf("stall%0d_ov", c), bus.out_valid, 1);
            chk($sformatf("stall%0d_q_DstData", c), bus.q_DstData, 16'h00AA);
            chk($sformatf("stall%0d_in_ready", c), bus.in_ready, 0);
            chk($sformatf("stall%0d_mem_req", c), bus.mem_req, 0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("stall_release_in_ready", bus.in_ready, 1);
        @(negedge clk);
        clear_in();
        #1;
        chk("stall_alu_drained", bus.out_valid, 0);
        chk("stall_load_req", bus.mem_req, 1);
        @(negedge clk);
        bus.out_ready = 1'b0;
        #1;
        chk("stall_load_ov", bus.out_valid, 1);
        chk("stall_load_MemData", bus.q_MemData, 16'h5A5A);
        chk("stall_load_DstReg", bus.q_DstReg, 7);
        chk("stall_load_req_done", bus.mem_req, 0);
        @(negedge clk);
        #1;
        chk("stall_load_held", bus.out_valid, 1);
        chk("stall_load_held_in_ready", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("stall_no_dup", bus.out_valid, 0);
        chk("stall_no_extra_req", bus.mem_req, 0);
        bus.mem_ready = 1'b0;

        // halt then an ALU op held valid
        @(negedge clk);
        bus.in_valid = 1'b1; bus.d_hlt = 1'b1;
        @(negedge clk);
        clear_in();
        bus.in_valid = 1'b1; bus.d_WriteReg = 1'b1; bus.d_DstData = 16'h0077;
        #1;
        chk("halt_q_hlt", bus.q_hlt, 1);
        chk("halt_ov", bus.out_valid, 1);
        chk("halt_halted", bus.halted, 1);
        chk("halt_in_ready", bus.in_ready, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("halt%0d_in_ready", c), bus.in_ready, 0);
            chk($sformatf("halt%0d_ov", c), bus.out_valid, 0);
            chk($sformatf("halt%0d_halted", c), bus.halted, 1);
        end
        clear_in();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
